// File: rtl/input_cond_if.sv
// Sensor/walk/reprogram conditioning signals between the synchronizer front end,
// the conditioning block and the controller FSM.
interface input_cond_if;
  logic sensor_sync;
  logic wr_sync_out;
  logic prog_sync;
  logic walk_ack;
  logic sensor_db;
  logic walk_pending;
  logic walk_overrun;
  logic prog_pulse;

  modport master (
    output sensor_sync, wr_sync_out, prog_sync, walk_ack,
    input  sensor_db, walk_pending, walk_overrun, prog_pulse
  );

  modport slave (
    input  sensor_sync, wr_sync_out, prog_sync, walk_ack,
    output sensor_db, walk_pending, walk_overrun, prog_pulse
  );
endinterface

// File: rtl/input_cond.sv
// Debounces sensor, walk-request and reprogram levels; latches walk requests
// until acknowledged and turns a debounced reprogram rise into a one-cycle pulse.
module input_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input logic         clk,
  input logic         reset,
  input_cond_if.slave bus
);

  localparam int unsigned NUM_IN = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Debouncer lanes: 0 = sensor, 1 = walk request, 2 = reprogram.
  logic [NUM_IN-1:0] raw;
  logic [NUM_IN-1:0] db_q, db_d;
  logic [CNT_W-1:0]  cnt_q [NUM_IN];
  logic [CNT_W-1:0]  cnt_d [NUM_IN];

  logic [1:0] prev_q, prev_d;
  logic [1:0] rise;
  logic       pending_q, pending_d;
  logic       overrun_q, overrun_d;
  logic       prog_pulse_q, prog_pulse_d;

  assign raw = {bus.prog_sync, bus.wr_sync_out, bus.sensor_sync};

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_d[i] = '0;
      if (raw[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) db_d[i] = ~db_q[i];
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // rise[0] = walk, rise[1] = prog; prev lags the debounced value by one edge.
  assign rise = db_q[2:1] & ~prev_q;

  always_comb begin
    prev_d       = db_q[2:1];
    prog_pulse_d = rise[1];
    overrun_d    = rise[0] & pending_q & ~bus.walk_ack;
    pending_d    = pending_q;
    if (rise[0])           pending_d = 1'b1;
    else if (bus.walk_ack) pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_q         <= '0;
      prev_q       <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      prog_pulse_q <= 1'b0;
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
    end else begin
      db_q         <= db_d;
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      prog_pulse_q <= prog_pulse_d;
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.sensor_db    = db_q[0];
  assign bus.walk_pending = pending_q;
  assign bus.walk_overrun = overrun_q;
  assign bus.prog_pulse   = prog_pulse_q;

endmodule

// File: doc/input_cond.md
INPUT_COND -- requirements
Module: input_cond

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive cycles an input must differ from its debounced value before the debounced value flips; legal range 2..255.
- REQ-002: Parameter CNT_W, default 8, meaning the debounce counter width; it SHALL hold DEBOUNCE_CYCLES-1.
- REQ-003: Port clk, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
- REQ-004: Port reset, input, 1 bit: synchronous, active-high reset, sampled on the clk rising edge.
- REQ-005: Port sensor_sync, input, 1 bit: synchronized vehicle sensor level.
- REQ-006: Port wr_sync_out, input, 1 bit: synchronized pedestrian walk-request level.
- REQ-007: Port prog_sync, input, 1 bit: synchronized reprogram-switch level.
- REQ-008: Port walk_ack, input, 1 bit: one-cycle pulse from the controller FSM meaning the walk phase has been serviced.
- REQ-009: Port sensor_db, output, 1 bit: debounced sensor level.
- REQ-010: Port walk_pending, output, 1 bit: sticky flag meaning a walk request is latched and awaiting service.
- REQ-011: Port walk_overrun, output, 1 bit: one-cycle pulse meaning a new walk request arrived while one was already pending.
- REQ-012: Port prog_pulse, output, 1 bit: one-cycle pulse on a debounced rising edge of reprogram.

Function
- REQ-013: Each of the three inputs SHALL have an independent debouncer consisting of a debounced-value register and a CNT_W-bit counter.
- REQ-014: Counter rules: while input == debounced value, the counter SHALL clear to 0; while input != debounced value and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
- REQ-015: Flip rule: when input != debounced value and counter == DEBOUNCE_CYCLES-1, the debounced value SHALL toggle and the counter SHALL clear, on the same edge.
- REQ-016: Debounce latency: an input level held constant for edges 1..N (N = DEBOUNCE_CYCLES) SHALL appear on the debounced value after edge N.
- REQ-017: Glitch rejection: an input deviation shorter than N edges SHALL NOT change the debounced value, and SHALL restart the count from 0.
- REQ-018: sensor_db SHALL be the sensor debouncer register driven directly, with no further logic.
- REQ-019: Edge detection SHALL register each debounced walk and prog value (prev); rise = db AND NOT prev.
- REQ-020: prog_pulse SHALL be registered and SHALL be high for exactly the one cycle following the edge after the debounced prog rise (edge N+1).
- REQ-021: walk_pending SHALL set on the edge after a debounced walk rise (edge N+1).
- REQ-022: walk_pending SHALL clear on an edge where walk_ack = 1 and no walk rise is present.
- REQ-023: A simultaneous walk rise and walk_ack SHALL leave walk_pending = 1, because the new request takes priority.
- REQ-024: A walk rise while walk_pending = 1 and walk_ack = 0 SHALL hold walk_pending = 1 and SHALL assert walk_overrun for one cycle.
- REQ-025: walk_ack while walk_pending = 0 SHALL be ignored, with no error output.
- REQ-026: A held-high request SHALL generate exactly one pending; a second request requires a debounced fall followed by a debounced rise.
- REQ-027: All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
- REQ-028: On a clk edge with reset = 1, all debounced values, prev registers and counters SHALL clear to 0.
- REQ-029: On a clk edge with reset = 1, sensor_db, walk_pending, walk_overrun and prog_pulse SHALL go to 0.
- REQ-030: Reset SHALL take priority over every other event, including walk_ack and an in-progress count.
- REQ-031: An input already high when reset releases SHALL be treated as a new rise after N edges.

Verification (N=4)
- REQ-032: Debounce latency: wr_sync_out 0->1 held -> debounced walk high after edge 4; walk_pending = 1 after edge 5; walk_overrun stays 0.
- REQ-033: Glitch rejection: sensor_sync high for 3 cycles then low -> sensor_db stays 0; a subsequent 4-cycle high -> sensor_db = 1 after its 4th edge.
- REQ-034: Request/ack: pending = 1, then walk_ack pulse -> pending = 0 next edge; wr_sync_out held high throughout -> pending stays 0 (no re-trigger).
- REQ-035: Simultaneous events: a second debounced rise on the same edge as walk_ack -> pending stays 1, overrun = 0; the same rise without ack -> overrun = 1 for exactly 1 cycle.
- REQ-036: Reprogram pulse: prog_sync held high for 10 cycles -> exactly one prog_pulse, high for one cycle following edge 5.
- REQ-037: Reset mid-operation: reset asserted at count 2 and again with pending = 1 -> all outputs 0 next edge; input still high after release -> pending re-sets after 5 further edges.
